// File: rtl/digit_prompt_checker_if.sv
// Bus interface for digit_prompt_checker.
// Carries the game control inputs, the random prompt digits, the keypad
// strobe and every status/score output. The master drives the game and
// the slave is the checker.
interface digit_prompt_checker_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               abort;
  logic [3:0]         rand_one;
  logic [3:0]         rand_two;
  logic [3:0]         rand_three;
  logic [3:0]         rand_four;
  logic               key_valid;
  logic [3:0]         key_digit;
  logic [15:0]        target_digits;
  logic [1:0]         cursor;
  logic               busy;
  logic               hit;
  logic               miss;
  logic               round_done;
  logic [SCORE_W-1:0] hit_cnt;
  logic [SCORE_W-1:0] miss_cnt;
  logic [7:0]         round_cnt;
  logic               game_over;

  modport master (
    output start, abort, rand_one, rand_two, rand_three, rand_four,
           key_valid, key_digit,
    input  target_digits, cursor, busy, hit, miss, round_done,
           hit_cnt, miss_cnt, round_cnt, game_over
  );

  modport slave (
    input  start, abort, rand_one, rand_two, rand_three, rand_four,
           key_valid, key_digit,
    output target_digits, cursor, busy, hit, miss, round_done,
           hit_cnt, miss_cnt, round_cnt, game_over
  );
endinterface

// File: rtl/digit_prompt_checker.sv
// digit_prompt_checker
// Latches four random digits as a prompt, checks keypad entries against it
// in order, and keeps saturating hit/miss tallies plus a round count. The
// game ends after NUM_ROUNDS completed rounds.
// Optional feature: define ROUND_TIMER_EN to add a per-round time limit of
// TIMEOUT_CYCLES clocks; expiry ends the round with a miss.
module digit_prompt_checker #(
  parameter int NUM_ROUNDS = 8,
  parameter int SCORE_W    = 8
`ifdef ROUND_TIMER_EN
  , parameter int TIMEOUT_CYCLES = 100_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  digit_prompt_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PROMPT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        target_q;
  logic [1:0]         cursor_q;
  logic               hit_q;
  logic               miss_q;
  logic [SCORE_W-1:0] hit_cnt_q;
  logic [SCORE_W-1:0] miss_cnt_q;
  logic [7:0]         round_cnt_q;
  logic               game_over_q;

  // Per-cycle events decoded by the FSM; all are forced low by abort.
  logic       new_game;
  logic       load_prompt;
  logic       key_hit;
  logic       key_miss;
  logic       advance;
  logic       round_end;
  logic [3:0] expected_digit;
  logic       last_round;

  // Digits above 9 are folded back into 0..5 so the prompt stays decimal.
  function automatic logic [3:0] fold_digit(input logic [3:0] d);
    return (d > 4'd9) ? (d - 4'd10) : d;
  endfunction

  assign expected_digit = target_q[{cursor_q, 2'b00} +: 4];
  assign last_round     = ({1'b0, round_cnt_q} + 9'd1) == 9'(NUM_ROUNDS);

`ifdef ROUND_TIMER_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q;
  logic               timer_expired;

  assign timer_expired = (timer_q == TIMER_LAST);

  // Round timer: held at zero outside PROMPT, so it starts at 0 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                timer_q <= '0;
    else if (state_q != PROMPT) timer_q <= '0;
    else                       timer_q <= timer_q + TIMER_W'(1);
  end
`endif

  // Next-state and event decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d     = state_q;
    new_game    = 1'b0;
    load_prompt = 1'b0;
    key_hit     = 1'b0;
    key_miss    = 1'b0;
    advance     = 1'b0;
    round_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          new_game = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_prompt = 1'b1;
        state_d     = PROMPT;
      end
      PROMPT: begin
        if (bus.key_valid) begin
          // Prompt digits are always 0..9, so an illegal key can never match.
          if (bus.key_digit == expected_digit) begin
            key_hit = 1'b1;
            if (cursor_q == 2'd3) state_d = DONE;
            else                  advance = 1'b1;
          end else begin
            key_miss = 1'b1;
          end
        end
`ifdef ROUND_TIMER_EN
        // The key is judged first; a completing hit wins over expiry.
        // Otherwise expiry ends the round, sharing the miss pulse with a
        // wrong key in the same cycle so the tally moves only once.
        if (timer_expired && (state_d != DONE)) begin
          key_miss = 1'b1;
          state_d  = DONE;
        end
`endif
      end
      DONE: begin
        round_end = 1'b1;
        state_d   = last_round ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything: back to IDLE with all state held.
    if (bus.abort) begin
      state_d     = IDLE;
      new_game    = 1'b0;
      load_prompt = 1'b0;
      key_hit     = 1'b0;
      key_miss    = 1'b0;
      advance     = 1'b0;
      round_end   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Prompt, cursor, result pulses and score counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q    <= '0;
      cursor_q    <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      round_cnt_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      hit_q  <= key_hit;
      miss_q <= key_miss;

      if (new_game) begin
        hit_cnt_q   <= '0;
        miss_cnt_q  <= '0;
        round_cnt_q <= '0;
        game_over_q <= 1'b0;
      end

      if (load_prompt) begin
        target_q <= {fold_digit(bus.rand_four), fold_digit(bus.rand_three),
                     fold_digit(bus.rand_two),  fold_digit(bus.rand_one)};
        cursor_q <= '0;
      end else if (advance) begin
        cursor_q <= cursor_q + 2'd1;
      end

      if (key_hit && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + SCORE_W'(1);
      if (key_miss && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + SCORE_W'(1);

      if (round_end) begin
        round_cnt_q <= round_cnt_q + 8'd1;
        if (last_round) game_over_q <= 1'b1;
      end
    end
  end

  assign bus.target_digits = target_q;
  assign bus.cursor        = cursor_q;
  assign bus.busy          = (state_q == LOAD) || (state_q == PROMPT);
  assign bus.hit           = hit_q;
  assign bus.miss          = miss_q;
  assign bus.round_done    = (state_q == DONE);
  assign bus.hit_cnt       = hit_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;
  assign bus.round_cnt     = round_cnt_q;
  assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_digit_prompt_checker.sv
// Directed testbench for digit_prompt_checker, built with NUM_ROUNDS=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// With ROUND_TIMER_EN defined the timer is set to 16 cycles and a timeout
// round replaces the miss-saturation sequence.
module tb_digit_prompt_checker;

  localparam int NUM_ROUNDS = 2;
  localparam int SCORE_W    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  digit_prompt_checker_if #(.SCORE_W(SCORE_W)) bus ();

  digit_prompt_checker #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .SCORE_W   (SCORE_W)
`ifdef ROUND_TIMER_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic set_rand(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
    bus.rand_four  = d3;
    bus.rand_three = d2;
    bus.rand_two   = d1;
    bus.rand_one   = d0;
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_target"},    bus.target_digits, 0);
    check({p, "_cursor"},    bus.cursor,        0);
    check({p, "_busy"},      bus.busy,          0);
    check({p, "_hit"},       bus.hit,           0);
    check({p, "_miss"},      bus.miss,          0);
    check({p, "_rdone"},     bus.round_done,    0);
    check({p, "_hit_cnt"},   bus.hit_cnt,       0);
    check({p, "_miss_cnt"},  bus.miss_cnt,      0);
    check({p, "_round_cnt"}, bus.round_cnt,     0);
    check({p, "_game_over"}, bus.game_over,     0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    set_rand(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Round 1: prompt {9,0,3,7}, keys 7,3,0,9.
    set_rand(4'd9, 4'd0, 4'd3, 4'd7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("r1_load_busy", bus.busy, 1);
    tick();
    check("r1_target", bus.target_digits, 16'h9037);
    check("r1_cursor0", bus.cursor, 0);
    press(4'd7);
    check("r1_hit0", bus.hit, 1);
    check("r1_cursor1", bus.cursor, 1);
    press(4'd3);
    check("r1_hit1", bus.hit, 1);
    press(4'd0);
    check("r1_cursor3", bus.cursor, 3);
    press(4'd9);
    check("r1_hit3", bus.hit, 1);
    check("r1_round_done", bus.round_done, 1);
    check("r1_busy_done", bus.busy, 0);
    check("r1_hit_cnt", bus.hit_cnt, 4);
    check("r1_miss_cnt", bus.miss_cnt, 0);
    tick();
    check("r1_round_cnt", bus.round_cnt, 1);
    check("r1_rdone_gone", bus.round_done, 0);
    check("r1_game_over", bus.game_over, 0);
    check("r2_load_busy", bus.busy, 1);

    // Round 2 prompt {C,1,8,5} folds to 16'h2185; a key during LOAD is dropped.
    set_rand(4'hC, 4'd1, 4'd8, 4'd5);
    press(4'd5);
    check("load_key_hit", bus.hit, 0);
    check("load_key_miss", bus.miss, 0);
    check("r2_target", bus.target_digits, 16'h2185);
    check("r2_cursor0", bus.cursor, 0);

    // Wrong key then illegal key: misses, cursor stays 0.
    press(4'd2);
    check("wrong_miss", bus.miss, 1);
    check("wrong_hit", bus.hit, 0);
    check("wrong_miss_cnt", bus.miss_cnt, 1);
    check("wrong_cursor", bus.cursor, 0);
    press(4'hC);
    check("illegal_miss", bus.miss, 1);
    check("illegal_miss_cnt", bus.miss_cnt, 2);
    check("illegal_cursor", bus.cursor, 0);
    press(4'd5);
    press(4'd8);
    press(4'd1);
    press(4'd2);
    check("r2_round_done", bus.round_done, 1);
    check("r2_hit_cnt", bus.hit_cnt, 8);
    tick();
    check("game_round_cnt", bus.round_cnt, 2);
    check("game_over_set", bus.game_over, 1);
    check("game_idle_busy", bus.busy, 0);

    // Keys in IDLE are ignored.
    press(4'd5);
    check("idle_key_hit", bus.hit, 0);
    check("idle_key_miss", bus.miss, 0);
    check("idle_hit_cnt", bus.hit_cnt, 8);

    // New game clears all counters.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("new_hit_cnt", bus.hit_cnt, 0);
    check("new_miss_cnt", bus.miss_cnt, 0);
    check("new_round_cnt", bus.round_cnt, 0);
    check("new_game_over", bus.game_over, 0);
    tick();
    press(4'd5);
    check("pre_abort_cursor", bus.cursor, 1);

    // Abort with a matching key in the same cycle.
    bus.abort = 1'b1;
    press(4'd8);
    bus.abort = 1'b0;
    check("abort_hit", bus.hit, 0);
    check("abort_miss", bus.miss, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_hit_cnt", bus.hit_cnt, 1);
    check("abort_cursor", bus.cursor, 1);
    check("abort_target", bus.target_digits, 16'h2185);

    // Start and abort together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);
    check("start_abort_hit_cnt", bus.hit_cnt, 1);

    // Asynchronous reset in the middle of PROMPT.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("prompt_busy", bus.busy, 1);
    press(4'd3);
    check("prompt_miss", bus.miss, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
`ifdef ROUND_TIMER_EN
    // No keys: timeout ends the round 16 cycles after PROMPT entry.
    begin
      int early;
      early = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (bus.round_done || bus.miss) early++;
      end
      check("timeout_not_early", early, 0);
      tick();
      check("timeout_miss", bus.miss, 1);
      check("timeout_round_done", bus.round_done, 1);
      check("timeout_miss_cnt", bus.miss_cnt, 1);
    end
`else
    // 260 wrong keys: miss counter saturates at all-ones.
    bus.key_valid = 1'b1;
    bus.key_digit = 4'hF;
    for (int i = 0; i < 260; i++) tick();
    bus.key_valid = 1'b0;
    check("sat_miss_cnt", bus.miss_cnt, 8'hFF);
    check("sat_cursor", bus.cursor, 0);
    check("sat_busy", bus.busy, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
